// File: rtl/compound_out_arbiter_types.sv
// Local types for the two-requester arbiter state machine.
`default_nettype none

package compound_out_arbiter_types;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } Sections;

  localparam int CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/top_level_types.sv
// Shared message types: the compound payload and its access mode.
`default_nettype none

package top_level_types;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic [7:0] x;
    logic [7:0] y;
  } CompoundType;

  localparam CompoundType COMPOUND_RESET = '{mode: READ, x: 8'd0, y: 8'd0};

endpackage

`default_nettype wire

// File: rtl/compound_out_arbiter.sv
// Two-input arbiter: grants A or B, holds the message in a one-entry output
// register until the consumer accepts it, and alternates priority under contention.
`default_nettype none

module compound_out_arbiter
  import top_level_types::*;
  import compound_out_arbiter_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  CompoundType       a_in,
  input  logic              a_in_sync,
  output logic              a_in_notify,
  input  CompoundType       b_in,
  input  logic              b_in_sync,
  output logic              b_in_notify,
  output CompoundType       c_out,
  input  logic              c_out_sync,
  output logic              c_out_notify,
  output logic              grant_id,
  output logic [CNT_W-1:0]  cnt_a_out,
  output logic [CNT_W-1:0]  cnt_b_out
);

  Sections            section_signal_q, section_signal_d;
  logic               prio_signal_q, prio_signal_d;
  CompoundType        c_out_q, c_out_d;
  logic               grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_signal_q <= IDLE;
      prio_signal_q    <= 1'b0;
      c_out_q          <= COMPOUND_RESET;
      grant_q          <= 1'b0;
      cnt_a_q          <= '0;
      cnt_b_q          <= '0;
    end else begin
      section_signal_q <= section_signal_d;
      prio_signal_q    <= prio_signal_d;
      c_out_q          <= c_out_d;
      grant_q          <= grant_d;
      cnt_a_q          <= cnt_a_d;
      cnt_b_q          <= cnt_b_d;
    end
  end

  always_comb begin
    a_in_notify      = 1'b0;
    b_in_notify      = 1'b0;
    section_signal_d = section_signal_q;
    prio_signal_d    = prio_signal_q;
    c_out_d          = c_out_q;
    grant_d          = grant_q;
    cnt_a_d          = cnt_a_q;
    cnt_b_d          = cnt_b_q;

    case (section_signal_q)
      IDLE: begin
        // rst gates the notifies so no requester sees a handshake during reset
        if (!rst) begin
          if (a_in_sync && (!b_in_sync || !prio_signal_q)) begin
            a_in_notify = 1'b1;
          end else if (b_in_sync) begin
            b_in_notify = 1'b1;
          end
        end
        if (a_in_notify) begin
          c_out_d          = a_in;
          grant_d          = 1'b0;
          cnt_a_d          = cnt_a_q + 8'd1;
          section_signal_d = SEND;
        end else if (b_in_notify) begin
          c_out_d          = b_in;
          grant_d          = 1'b1;
          cnt_b_d          = cnt_b_q + 8'd1;
          section_signal_d = SEND;
        end
      end
      SEND: begin
        if (c_out_sync) begin
          section_signal_d = IDLE;
          prio_signal_d    = ~grant_q;
        end
      end
      default: section_signal_d = IDLE;
    endcase
  end

  assign c_out        = c_out_q;
  assign c_out_notify = (section_signal_q == SEND);
  assign grant_id     = grant_q;
  assign cnt_a_out    = cnt_a_q;
  assign cnt_b_out    = cnt_b_q;

endmodule

`default_nettype wire

// File: tb/tb_compound_out_arbiter.sv
// Directed, table-driven bench for compound_out_arbiter plus multi-cycle corner sequences.
`default_nettype none

module tb_compound_out_arbiter;
  import top_level_types::*;

  logic        clk;
  logic        rst;
  CompoundType a_in, b_in, c_out;
  logic        a_in_sync, b_in_sync, c_out_sync;
  logic        a_in_notify, b_in_notify, c_out_notify, grant_id;
  logic [7:0]  cnt_a_out, cnt_b_out;

  int applied;
  int miscompares;

  compound_out_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .a_in_sync    (a_in_sync),
    .a_in_notify  (a_in_notify),
    .b_in         (b_in),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .c_out        (c_out),
    .c_out_sync   (c_out_sync),
    .c_out_notify (c_out_notify),
    .grant_id     (grant_id),
    .cnt_a_out    (cnt_a_out),
    .cnt_b_out    (cnt_b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        a_s;
    CompoundType a_d;
    logic        b_s;
    CompoundType b_d;
    logic        c_s;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic CompoundType mk(mode_e m, logic [7:0] x, logic [7:0] y);
    CompoundType r;
    r.mode = m;
    r.x    = x;
    r.y    = y;
    return r;
  endfunction

  // Expected-output packing: {a_notify, b_notify, c_notify, grant, c_out, cnt_a, cnt_b}
  function automatic logic [36:0] ex(logic an, logic bn, logic cn, logic g,
                                     CompoundType c, logic [7:0] ca, logic [7:0] cb);
    return {an, bn, cn, g, c, ca, cb};
  endfunction

  function automatic logic [36:0] act();
    return {a_in_notify, b_in_notify, c_out_notify, grant_id, c_out, cnt_a_out, cnt_b_out};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    a_in_sync  = 1'b0;
    b_in_sync  = 1'b0;
    c_out_sync = 1'b0;
    a_in       = mk(READ, 8'd0, 8'd0);
    b_in       = mk(READ, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    CompoundType z, held;
    logic exp_g;
    applied     = 0;
    miscompares = 0;
    z = mk(READ, 8'd0, 8'd0);

    vecs[0]  = '{1'b0, z,                 1'b0, z,                 1'b0, ex(0,0,0,0, z,                 8'd0, 8'd0)};
    vecs[1]  = '{1'b1, mk(WRITE,5,1),     1'b0, z,                 1'b0, ex(1,0,0,0, z,                 8'd0, 8'd0)};
    vecs[2]  = '{1'b0, z,                 1'b0, z,                 1'b0, ex(0,0,1,0, mk(WRITE,5,1),     8'd1, 8'd0)};
    vecs[3]  = '{1'b1, mk(READ,9,9),      1'b1, mk(WRITE,3,4),     1'b1, ex(0,0,1,0, mk(WRITE,5,1),     8'd1, 8'd0)};
    vecs[4]  = '{1'b1, mk(READ,9,9),      1'b1, mk(WRITE,3,4),     1'b0, ex(0,1,0,0, mk(WRITE,5,1),     8'd1, 8'd0)};
    vecs[5]  = '{1'b0, z,                 1'b0, z,                 1'b1, ex(0,0,1,1, mk(WRITE,3,4),     8'd1, 8'd1)};
    vecs[6]  = '{1'b0, z,                 1'b0, z,                 1'b0, ex(0,0,0,1, mk(WRITE,3,4),     8'd1, 8'd1)};
    vecs[7]  = '{1'b0, z,                 1'b1, mk(READ,2,2),      1'b0, ex(0,1,0,1, mk(WRITE,3,4),     8'd1, 8'd1)};
    vecs[8]  = '{1'b0, z,                 1'b0, z,                 1'b1, ex(0,0,1,1, mk(READ,2,2),      8'd1, 8'd2)};
    vecs[9]  = '{1'b1, mk(WRITE,7,7),     1'b1, mk(READ,1,1),      1'b0, ex(1,0,0,1, mk(READ,2,2),      8'd1, 8'd2)};
    vecs[10] = '{1'b0, z,                 1'b0, z,                 1'b1, ex(0,0,1,0, mk(WRITE,7,7),     8'd2, 8'd2)};
    vecs[11] = '{1'b0, z,                 1'b0, z,                 1'b0, ex(0,0,0,0, mk(WRITE,7,7),     8'd2, 8'd2)};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      a_in_sync  = vecs[i].a_s;
      a_in       = vecs[i].a_d;
      b_in_sync  = vecs[i].b_s;
      b_in       = vecs[i].b_d;
      c_out_sync = vecs[i].c_s;
      #3;
      check($sformatf("vec%0d", i), 64'(act()), 64'(vecs[i].exp));
      step();
    end

    // Contention: grants must alternate starting with A
    do_reset();
    a_in = mk(WRITE, 8'd1, 8'hAA);
    b_in = mk(READ,  8'd2, 8'hBB);
    a_in_sync = 1'b1; b_in_sync = 1'b1; c_out_sync = 1'b1;
    for (int m = 0; m < 8; m++) begin
      exp_g = m[0];
      #3 check($sformatf("fair_notify%0d", m), 64'({a_in_notify, b_in_notify}),
               exp_g ? 64'd1 : 64'd2);
      step();
      #3 check($sformatf("fair_send%0d", m), 64'({c_out_notify, grant_id, c_out}),
               64'({1'b1, exp_g, exp_g ? b_in : a_in}));
      step();
    end
    check("fair_counts", 64'({cnt_a_out, cnt_b_out}), 64'({8'd4, 8'd4}));
    a_in_sync = 1'b0; b_in_sync = 1'b0; c_out_sync = 1'b0;

    // Backpressure: held message and blocked requester while consumer stalls
    do_reset();
    held = mk(WRITE, 8'h33, 8'h44);
    a_in = held; a_in_sync = 1'b1;
    #3 check("bp_accept", 64'(a_in_notify), 64'd1);
    step();
    a_in = mk(READ, 8'h55, 8'h66);
    for (int k = 0; k < 5; k++) begin
      #3 check($sformatf("bp_hold%0d", k), 64'({a_in_notify, b_in_notify, c_out_notify, c_out}),
               64'({1'b0, 1'b0, 1'b1, held}));
      step();
    end
    a_in_sync = 1'b0; c_out_sync = 1'b1;
    #3 check("bp_release", 64'(c_out_notify), 64'd1);
    step();
    c_out_sync = 1'b0;
    #3 check("bp_idle", 64'({c_out_notify, cnt_a_out}), 64'({1'b0, 8'd1}));

    // Reset while holding a message; priority was B-favoured before reset
    do_reset();
    a_in = mk(WRITE, 8'd1, 8'd1); a_in_sync = 1'b1; c_out_sync = 1'b1;
    step();
    step();
    a_in = mk(READ, 8'd7, 8'd0); c_out_sync = 1'b0;
    step();
    #3 check("rst_held", 64'({c_out_notify, c_out}), 64'({1'b1, mk(READ, 8'd7, 8'd0)}));
    rst = 1'b1;
    #1 check("rst_async", 64'(act()), 64'(ex(0,0,0,0, z, 8'd0, 8'd0)));
    step();
    rst = 1'b0;
    a_in_sync = 1'b0; c_out_sync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3 check($sformatf("rst_nodeliver%0d", k), 64'(c_out_notify), 64'd0);
      step();
    end
    a_in_sync = 1'b1; b_in_sync = 1'b1;
    #3 check("rst_prio", 64'({a_in_notify, b_in_notify}), 64'd2);
    a_in_sync = 1'b0; b_in_sync = 1'b0; c_out_sync = 1'b0;

    // Counter wrap: 256 A transfers at one message per two cycles
    do_reset();
    a_in = mk(WRITE, 8'd9, 8'd9); a_in_sync = 1'b1; c_out_sync = 1'b1;
    repeat (509) @(posedge clk);
    #1 check("wrap_255", 64'(cnt_a_out), 64'd255);
    repeat (2) @(posedge clk);
    #1 check("wrap_0", 64'({cnt_a_out, cnt_b_out}), 64'd0);
    a_in_sync = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/compound_out_arbiter.md
COMPOUND_OUT_ARBITER -- requirements
Module: compound_out_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port a_in, input, CompoundType, message offered by requester A.
REQ-004 SHALL have port a_in_sync, input, 1, A has a valid message on a_in.
REQ-005 SHALL have port a_in_notify, output, 1, arbiter reads a_in this cycle; transfer when a_in_sync && a_in_notify.
REQ-006 SHALL have ports b_in, b_in_sync and b_in_notify, with the same directions, widths and meanings for requester B.
REQ-007 SHALL have port c_out, output, CompoundType, granted message towards the shared consumer.
REQ-008 SHALL have port c_out_sync, input, 1, consumer ready.
REQ-009 SHALL have port c_out_notify, output, 1, c_out valid; transfer when c_out_sync && c_out_notify.
REQ-010 SHALL have port grant_id, output, 1, source of the held message: 0 = A, 1 = B.

Function
REQ-011 SHALL implement a two-state FSM (Sections: idle, send) held in section_signal.
REQ-012 SHALL, in idle, assert at most one of a_in_notify/b_in_notify, combinationally from section_signal, the syncs and prio_signal.
REQ-013 SHALL grant the sole requester when only one sync is high; when both are high, SHALL grant A if prio_signal=0, else B.
REQ-014 SHALL, on an idle transfer, register the granted message into c_out and the source into grant_id, and enter send next cycle.
REQ-015 SHALL assert c_out_notify exactly while in send, one cycle after acceptance; both in_notify SHALL be 0 in send.
REQ-016 SHALL hold c_out and grant_id stable throughout send until c_out_sync is sampled high.
REQ-017 SHALL, on the send handshake, return to idle and set prio_signal to the complement of grant_id.
REQ-018 SHALL, with no sync high in idle, remain in idle with prio_signal and c_out unchanged.
REQ-019 SHALL pass all CompoundType fields (mode, x, y) unmodified; no width conversion.
REQ-020 SHALL sustain a maximum throughput of one message per two cycles, with an idle-to-c_out latency of one cycle.
REQ-021 SHALL keep transfer counters cnt_a and cnt_b (8 bit, wrap 255->0) incremented on each accepted input, exposed as outputs cnt_a_out and cnt_b_out.

Reset
REQ-022 SHALL on rst set: section_signal=idle, prio_signal=0, c_out.mode=read, c_out.x=0, c_out.y=0, grant_id=0, c_out_notify=0, cnt_a=cnt_b=0.
REQ-023 SHALL drop a message held in send when rst is asserted; it is never delivered.
REQ-024 SHALL hold a_in_notify and b_in_notify at 0 while rst is high.

Structure
REQ-025 SHALL take CompoundType and its mode enum (read, write) from top_level_types.
REQ-026 SHALL define the Sections enum (idle, send) in package compound_out_arbiter_types.
REQ-027 SHALL have no sub-module; the grant selection SHALL be an inline always_comb.

Verification
REQ-028 SHALL cover solo requester: A offers {write,5,1} with B idle -> a_in_notify=1 same cycle; next cycle c_out={write,5,1}, c_out_notify=1, grant_id=0.
REQ-029 SHALL cover contention fairness: both syncs held high and c_out_sync=1 for 8 messages -> grants alternate A,B,A,B...; cnt_a=cnt_b=4.
REQ-030 SHALL cover backpressure: c_out_sync=0 for 5 cycles in send -> c_out stable, in_notify=0; on sync high, one transfer, then idle.
REQ-031 SHALL cover reset mid-send: rst pulsed while holding {read,7,0} -> c_out_notify=0, c_out={read,0,0}, prio=0; the message is never seen.
REQ-032 SHALL cover counter wrap: 256 A transfers -> cnt_a_out returns to 0; cnt_b_out stays 0.
